// File: rtl/ternary_neuron_acc.sv
// ternary_neuron_acc: accumulates signed popcount differences (pos - neg) over
// up to MAX_BEATS segments per neuron, then thresholds the sum into a trit.
// Optional feature macro: TNA_SATURATE_EN (saturating accumulator + out_sat).
module ternary_neuron_acc #(
  parameter int PC_W      = 6,
  parameter int ACC_W     = 10,
  parameter int MAX_BEATS = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PC_W-1:0]         pos_cnt,
  input  logic [PC_W-1:0]         neg_cnt,
  input  logic                    in_last,
  input  logic signed [ACC_W-1:0] th_hi,
  input  logic signed [ACC_W-1:0] th_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_trit,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [3:0]              out_beats,
  output logic                    out_ovf,
  output logic                    out_sat
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]              beats_q, beats_d;
  logic                    out_valid_q, out_valid_d;
  logic [1:0]              out_trit_q, out_trit_d;
  logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [3:0]              out_beats_q, out_beats_d;
  logic                    out_ovf_q, out_ovf_d;

  logic                    accept;
  logic                    close;
  logic signed [ACC_W:0]   diff;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_new;
  logic [3:0]              beats_new;
  logic                    clamp;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_trit  = out_trit_q;
  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;
  assign out_ovf   = out_ovf_q;

  // Datapath: difference, accumulate (wrap or clamp), beat count, close decision
  always_comb begin
    diff      = $signed({{(ACC_W+1-PC_W){1'b0}}, pos_cnt} -
                        {{(ACC_W+1-PC_W){1'b0}}, neg_cnt});
    base      = (state_q == RUN) ? acc_q : '0;
    beats_new = (state_q == RUN) ? beats_q + 4'd1 : 4'd1;
    close     = in_last || (beats_new == 4'(MAX_BEATS));
    clamp     = 1'b0;
`ifdef TNA_SATURATE_EN
    begin
      logic signed [ACC_W+1:0] sum_wide;
      sum_wide = (ACC_W+2)'(base) + (ACC_W+2)'(diff);
      if (sum_wide > $signed({3'b000, {(ACC_W-1){1'b1}}})) begin
        acc_new = {1'b0, {(ACC_W-1){1'b1}}};
        clamp   = 1'b1;
      end else if (sum_wide < $signed({3'b111, {(ACC_W-1){1'b0}}})) begin
        acc_new = {1'b1, {(ACC_W-1){1'b0}}};
        clamp   = 1'b1;
      end else begin
        acc_new = ACC_W'(sum_wide);
      end
    end
`else
    acc_new = base + ACC_W'(diff);
`endif
  end

  // Next-state and accumulator/output-register update
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    out_valid_d = out_ready ? 1'b0 : out_valid_q;
    out_trit_d  = out_trit_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    if (accept) begin
      acc_d   = acc_new;
      beats_d = beats_new;
      if (close) begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_sum_d   = acc_new;
        out_beats_d = beats_new;
        out_ovf_d   = !in_last;
        if (acc_new > th_hi)      out_trit_d = 2'b01;
        else if (acc_new < th_lo) out_trit_d = 2'b11;
        else                      out_trit_d = 2'b00;
      end else begin
        state_d = RUN;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      out_trit_q  <= 2'b00;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
      out_trit_q  <= out_trit_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

`ifdef TNA_SATURATE_EN
  logic sat_q, sat_d, out_sat_q, out_sat_d;

  // Sticky per-neuron saturation flag, reported on close
  always_comb begin
    sat_d     = sat_q;
    out_sat_d = out_sat_q;
    if (accept) begin
      sat_d = ((state_q == RUN) && sat_q) || clamp;
      if (close) out_sat_d = sat_d;
    end
  end

  // Saturation flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q     <= 1'b0;
      out_sat_q <= 1'b0;
    end else begin
      sat_q     <= sat_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign out_sat = out_sat_q;
`else
  assign out_sat = clamp;
`endif

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Scoreboard bench for ternary_neuron_acc: a behavioural model pushes expected
// results as beats are accepted; a monitor pops and compares on each handshake.
module tb_ternary_neuron_acc;
  localparam int PC_W = 6, ACC_W = 10, MAX_BEATS = 15;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_last;
  logic [PC_W-1:0] pos_cnt, neg_cnt;
  logic signed [ACC_W-1:0] th_hi, th_lo;
  logic out_valid, out_ready;
  logic [1:0] out_trit;
  logic signed [ACC_W-1:0] out_sum;
  logic [3:0] out_beats;
  logic out_ovf, out_sat;

  int   rdy_mode;  // 0: ready high, 1: ready low, 2: random
  logic rnd_bit = 1'b1;

  ternary_neuron_acc #(.PC_W(PC_W), .ACC_W(ACC_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pos_cnt(pos_cnt), .neg_cnt(neg_cnt), .in_last(in_last),
    .th_hi(th_hi), .th_lo(th_lo), .out_valid(out_valid), .out_ready(out_ready),
    .out_trit(out_trit), .out_sum(out_sum), .out_beats(out_beats),
    .out_ovf(out_ovf), .out_sat(out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign out_ready = (rdy_mode == 2) ? rnd_bit : (rdy_mode == 0);

  typedef struct {
    int trit; int sum; int beats; int ovf; int sat;
  } res_t;

  res_t sbq[$];
  int checks = 0, failures = 0;
  int m_acc = 0, m_beats = 0, m_sat = 0;
  bit m_run = 1'b0;

  task automatic check(string tag, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_beat(int pos, int neg, bit last, int hi, int lo);
    int s, nb, sat, nsat;
    logic [31:0] sv;
    logic signed [ACC_W-1:0] w;
    res_t r;
    sat = 0;
    s = (m_run ? m_acc : 0) + pos - neg;
`ifdef TNA_SATURATE_EN
    if (s > 511) begin s = 511; sat = 1; end
    else if (s < -512) begin s = -512; sat = 1; end
`else
    sv = s;
    w  = sv[ACC_W-1:0];
    s  = int'(w);
`endif
    nb   = m_run ? m_beats + 1 : 1;
    nsat = (m_run ? m_sat : 0) | sat;
    if (last || nb == MAX_BEATS) begin
      r.sum = s; r.beats = nb; r.ovf = last ? 0 : 1; r.sat = nsat;
      r.trit = (s > hi) ? 1 : ((s < lo) ? 3 : 0);
      sbq.push_back(r);
      m_run = 1'b0;
    end else begin
      m_run = 1'b1; m_acc = s; m_beats = nb; m_sat = nsat;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(int pos, int neg, bit last, int hi, int lo);
    int waited = 0;
    in_valid = 1'b1; pos_cnt = PC_W'(pos); neg_cnt = PC_W'(neg);
    in_last = last; th_hi = ACC_W'(hi); th_lo = ACC_W'(lo);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
    end
    model_beat(pos, neg, last, hi, lo);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every result at its handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) check("unexpected_result", 1, 0);
      else begin
        res_t e;
        e = sbq.pop_front();
        check("trit",  int'(out_trit),    e.trit);
        check("sum",   int'(out_sum),     e.sum);
        check("beats", int'(out_beats),   e.beats);
        check("ovf",   int'(out_ovf),     e.ovf);
        check("sat",   int'(out_sat),     e.sat);
      end
    end
  end

  initial begin
    int n, len, waited;
    rst = 1'b1; rdy_mode = 0; in_valid = 1'b0; in_last = 1'b0;
    pos_cnt = '0; neg_cnt = '0; th_hi = '0; th_lo = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_sum",   int'(out_sum),   0);
    check("rst_beats", int'(out_beats), 0);
    check("rst_trit",  int'(out_trit),  0);
    check("rst_ovf",   int'(out_ovf) + int'(out_sat), 0);
    check("rst_ready", int'(in_ready),  1);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);

    // single beat, latency 1
    send_beat(20, 5, 1, 10, -10);
    check("lat_valid", int'(out_valid), 1);
    idle(2);

    // three beats to a negative sum
    send_beat(3, 9, 0, 10, -10);
    send_beat(0, 7, 0, 10, -10);
    send_beat(2, 2, 1, 10, -10);
    idle(2);

    // backpressure then back-to-back drain
    rdy_mode = 1;
    send_beat(20, 5, 1, 10, -10);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready),  0);
      check("bp_valid",    int'(out_valid), 1);
      check("bp_sum",      int'(out_sum),   15);
    end
    @(posedge clk); #1;
    rdy_mode = 0;
    send_beat(35, 0, 1, 10, -10);
    check("no_bubble", int'(out_valid), 1);
    idle(2);
    check("drained_valid", int'(out_valid), 0);

    // forced close at MAX_BEATS
    repeat (MAX_BEATS) send_beat(35, 0, 0, 10, -10);
    idle(2);

    // RUN holds while no beat is offered
    send_beat(4, 1, 0, 2, -2);
    idle(5);
    send_beat(2, 0, 1, 2, -2);
    idle(2);

    // reset mid-neuron discards the partial sum
    send_beat(10, 0, 0, 10, -10);
    send_beat(10, 0, 0, 10, -10);
    rst = 1'b1; m_run = 1'b0;
    #3 check("mid_rst_valid", int'(out_valid), 0);
    idle(1);
    rst = 1'b0;
    idle(1);
    send_beat(1, 0, 1, 10, -10);
    idle(2);

    // random neurons with random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(1, 17);
      for (int b = 0; b < len; b++) begin
        n = $urandom_range(0, 80) - 40;
        send_beat($urandom_range(0, 35), $urandom_range(0, 35), b == len - 1,
                  n, $urandom_range(0, 80) - 40);
      end
    end

    rdy_mode = 0;
    waited = 0;
    while (sbq.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("drain_queue", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
